// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: time-multiplexed scan controller for an N-digit common-anode 7-segment display.
// Define DISP_SCAN_LZB_EN to enable leading-zero blanking.
module disp_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    upd_valid,
    input  logic [4*NUM_DIGITS-1:0] upd_bcd,
    input  logic [NUM_DIGITS-1:0]   upd_dp,
    output logic                    upd_ready,
    output logic [3:0]              bcd_out,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    dp_n,
    output logic                    frame_done
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    typedef enum logic {
        S_BLANK = 1'b0,
        S_SHOW  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [PW-1:0]           presc_q, presc_d;
    logic                    wrap_q, wrap_d;
    logic [4*NUM_DIGITS-1:0] disp_bcd_q, disp_bcd_d;
    logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic [4*NUM_DIGITS-1:0] pend_bcd_q, pend_bcd_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                    pend_q, pend_d;
    logic [3:0]              bcd_out_q, bcd_out_d;
    logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
    logic                    dp_n_q, dp_n_d;
    logic                    frame_done_q, frame_done_d;
    logic                    upd_ready_q, upd_ready_d;

    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_blank;
    logic [NUM_DIGITS-1:0]   idx_onehot;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic                    xfer;

`ifdef DISP_SCAN_LZB_EN
    // Walk from the most significant digit down; digit 0 is never blanked.
    always_comb begin : lzb_mask
        logic zeros_above;
        zeros_above = 1'b1;
        lz_blank    = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zeros_above = zeros_above && (disp_bcd_q[4*i +: 4] == 4'd0);
            lz_blank[i] = zeros_above && !disp_dp_q[i];
        end
    end
`else
    assign lz_blank = '0;
`endif

    always_comb begin : digit_select
        cur_nib    = 4'd0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        idx_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_nib       = disp_bcd_q[4*i +: 4];
                cur_dp        = disp_dp_q[i];
                cur_blank     = lz_blank[i];
                idx_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin : next_state
        state_d      = state_q;
        idx_d        = idx_q;
        presc_d      = presc_q;
        wrap_d       = wrap_q;
        disp_bcd_d   = disp_bcd_q;
        disp_dp_d    = disp_dp_q;
        pend_bcd_d   = pend_bcd_q;
        pend_dp_d    = pend_dp_q;
        pend_d       = pend_q;
        bcd_out_d    = bcd_out_q;
        an_n_d       = '1;
        dp_n_d       = 1'b1;
        frame_done_d = 1'b0;
        xfer         = upd_valid && upd_ready_q;

        case (state_q)
            S_BLANK: begin
                // Decoder input changes while all anodes are off to avoid ghosting.
                bcd_out_d    = cur_nib;
                frame_done_d = wrap_q;
                presc_d      = '0;
                state_d      = S_SHOW;
            end
            S_SHOW: begin
                if ((cur_nib <= 4'd9) && !cur_blank) begin
                    an_n_d = ~idx_onehot;
                    dp_n_d = ~cur_dp;
                end
                if (presc_q == PRE_LAST) begin
                    state_d = S_BLANK;
                    presc_d = '0;
                    wrap_d  = (idx_q == IDX_LAST);
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        // Frame boundary: staged contents take over from digit 0 onward.
                        if (pend_q) begin
                            disp_bcd_d = pend_bcd_q;
                            disp_dp_d  = pend_dp_q;
                            pend_d     = 1'b0;
                        end
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            default: state_d = S_BLANK;
        endcase

        // Cannot coincide with a commit: ready is low whenever something is pending.
        if (xfer) begin
            pend_bcd_d = upd_bcd;
            pend_dp_d  = upd_dp;
            pend_d     = 1'b1;
        end
        upd_ready_d = !pend_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_BLANK;
            idx_q        <= '0;
            presc_q      <= '0;
            wrap_q       <= 1'b0;
            disp_bcd_q   <= '0;
            disp_dp_q    <= '0;
            pend_bcd_q   <= '0;
            pend_dp_q    <= '0;
            pend_q       <= 1'b0;
            bcd_out_q    <= 4'd0;
            an_n_q       <= '1;
            dp_n_q       <= 1'b1;
            frame_done_q <= 1'b0;
            upd_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            presc_q      <= presc_d;
            wrap_q       <= wrap_d;
            disp_bcd_q   <= disp_bcd_d;
            disp_dp_q    <= disp_dp_d;
            pend_bcd_q   <= pend_bcd_d;
            pend_dp_q    <= pend_dp_d;
            pend_q       <= pend_d;
            bcd_out_q    <= bcd_out_d;
            an_n_q       <= an_n_d;
            dp_n_q       <= dp_n_d;
            frame_done_q <= frame_done_d;
            upd_ready_q  <= upd_ready_d;
        end
    end

    assign upd_ready  = upd_ready_q;
    assign bcd_out    = bcd_out_q;
    assign an_n       = an_n_q;
    assign dp_n       = dp_n_q;
    assign frame_done = frame_done_q;

endmodule
